// File: rtl/fir_arb_pkg.sv
// Shared types and default sizing for the FIR stream arbiter.
// Holds the FSM state type and the channel-index width helper.
package fir_arb_pkg;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NUM_CH_DEF    = 4;
  localparam int DATA_W_DEF    = 16;
  localparam int RES_W_DEF     = 32;
  localparam int TAG_DEPTH_DEF = 4;
  localparam int CH_IDX_W      = idx_w(NUM_CH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_XFER
  } arb_state_e;

endpackage

// File: rtl/fir_arb_tag_fifo.sv
// Tag FIFO: remembers which channel owns each packet inside the FIR.
// Synchronous push/pop, pointers wrap modulo DEPTH.
module fir_arb_tag_fifo
  import fir_arb_pkg::*;
#(
  parameter int WIDTH = CH_IDX_W,
  parameter int DEPTH = TAG_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = idx_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/fir_stream_arbiter.sv
// Round-robin packet arbiter in front of a shared FIR, with tagged result demux.
// Define FIR_ARB_STATS_EN to build the per-channel completed-packet counters.
module fir_stream_arbiter
  import fir_arb_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RES_W     = RES_W_DEF,
  parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] s_tdata,
  input  logic [NUM_CH-1:0]        s_tvalid,
  input  logic [NUM_CH-1:0]        s_tlast,
  output logic [NUM_CH-1:0]        s_tready,
  output logic [DATA_W-1:0]        m_axis_fir_tdata,
  output logic                     m_axis_fir_tvalid,
  output logic                     m_axis_fir_tlast,
  input  logic                     m_axis_fir_tready,
  input  logic [RES_W-1:0]         s_axis_fir_tdata,
  input  logic                     s_axis_fir_tvalid,
  input  logic                     s_axis_fir_tlast,
  output logic                     s_axis_fir_tready,
  output logic [RES_W-1:0]         res_tdata,
  output logic                     res_tlast,
  output logic [NUM_CH-1:0]        res_tvalid,
  input  logic [NUM_CH-1:0]        res_tready,
  output logic [NUM_CH*16-1:0]     stat_pkts
);

  localparam int CH_W  = idx_w(NUM_CH);
  localparam int CNT_W = $clog2(TAG_DEPTH+1);

  arb_state_e      state_q, state_d;
  logic [CH_W-1:0] grant_q, grant_d;
  logic [CH_W-1:0] pick;
  logic            pick_vld;
  int              idx;

  logic             tag_push, tag_pop;
  logic             tag_full, tag_empty;
  logic [CH_W-1:0]  tag_head;
  logic [CNT_W-1:0] tag_cnt;
  logic             tag_room;

  // Registered occupancy only: a pop in this cycle frees room next cycle.
  assign tag_room = !tag_full && (tag_cnt < CNT_W'(TAG_DEPTH));

  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(grant_q) + i) % NUM_CH;
      if (!pick_vld && s_tvalid[CH_W'(idx)]) begin
        pick_vld = 1'b1;
        pick     = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    tag_push          = 1'b0;
    s_tready          = '0;
    m_axis_fir_tdata  = '0;
    m_axis_fir_tvalid = 1'b0;
    m_axis_fir_tlast  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|s_tvalid) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (pick_vld && tag_room) begin
          grant_d  = pick;
          tag_push = 1'b1;
          state_d  = ST_XFER;
        end
      end
      ST_XFER: begin
        m_axis_fir_tdata  = s_tdata[grant_q*DATA_W +: DATA_W];
        m_axis_fir_tvalid = s_tvalid[grant_q];
        m_axis_fir_tlast  = s_tlast[grant_q];
        s_tready[grant_q] = m_axis_fir_tready;
        if (s_tvalid[grant_q] && m_axis_fir_tready && s_tlast[grant_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= CH_W'(NUM_CH-1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  fir_arb_tag_fifo #(
    .WIDTH (CH_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tag_push),
    .push_data (pick),
    .pop       (tag_pop),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_cnt)
  );

  assign res_tdata = s_axis_fir_tdata;
  assign res_tlast = s_axis_fir_tlast;
  assign tag_pop   = !tag_empty && s_axis_fir_tvalid &&
                     res_tready[tag_head] && s_axis_fir_tlast;

  always_comb begin
    res_tvalid        = '0;
    s_axis_fir_tready = 1'b0;
    if (!tag_empty) begin
      res_tvalid[tag_head] = s_axis_fir_tvalid;
      s_axis_fir_tready    = res_tready[tag_head];
    end
  end

`ifdef FIR_ARB_STATS_EN
  logic [NUM_CH-1:0][15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (tag_pop && stat_q[tag_head] != 16'hFFFF) begin
      stat_d[tag_head] = stat_q[tag_head] + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stat_q <= '0;
    else       stat_q <= stat_d;
  end

  assign stat_pkts = stat_q;
`else
  assign stat_pkts = '0;
`endif

endmodule

// File: tb/tb_fir_stream_arbiter.sv
// Directed bench for fir_stream_arbiter: packet sources, FIR result source,
// and beat logs checked against hand-computed expectations.
module tb_fir_stream_arbiter;

  localparam int NC = 4;
  localparam int DW = 16;
  localparam int RW = 32;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [NC*DW-1:0]   s_tdata;
  logic [NC-1:0]      s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]      m_axis_fir_tdata;
  logic               m_axis_fir_tvalid, m_axis_fir_tlast;
  logic               m_axis_fir_tready;
  logic [RW-1:0]      s_axis_fir_tdata;
  logic               s_axis_fir_tvalid, s_axis_fir_tlast;
  logic               s_axis_fir_tready;
  logic [RW-1:0]      res_tdata;
  logic               res_tlast;
  logic [NC-1:0]      res_tvalid, res_tready;
  logic [NC*16-1:0]   stat_pkts;

  always #5 clk = ~clk;

  fir_stream_arbiter u_dut (
    .clk               (clk),
    .reset             (reset),
    .s_tdata           (s_tdata),
    .s_tvalid          (s_tvalid),
    .s_tlast           (s_tlast),
    .s_tready          (s_tready),
    .m_axis_fir_tdata  (m_axis_fir_tdata),
    .m_axis_fir_tvalid (m_axis_fir_tvalid),
    .m_axis_fir_tlast  (m_axis_fir_tlast),
    .m_axis_fir_tready (m_axis_fir_tready),
    .s_axis_fir_tdata  (s_axis_fir_tdata),
    .s_axis_fir_tvalid (s_axis_fir_tvalid),
    .s_axis_fir_tlast  (s_axis_fir_tlast),
    .s_axis_fir_tready (s_axis_fir_tready),
    .res_tdata         (res_tdata),
    .res_tlast         (res_tlast),
    .res_tvalid        (res_tvalid),
    .res_tready        (res_tready)
    ,.stat_pkts        (stat_pkts)
  );

  int n_chk = 0;
  int n_pass = 0;

  int          pkts [NC];
  int          beat [NC];
  int          len  [NC];
  logic [15:0] base [NC];
  logic [NC-1:0] fire;
  bit          res_en;

  logic [15:0] mq_data [$];
  bit          mq_last [$];
  int          mq_ch   [$];
  logic [31:0] rq      [$];
  logic [31:0] rl_data [$];
  int          rl_ch   [$];

  logic [63:0] seq;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int oh2i(input logic [NC-1:0] v);
    int r;
    r = -1;
    for (int i = NC-1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  task automatic drive();
    for (int c = 0; c < NC; c++) begin
      s_tvalid[c] = (pkts[c] > 0);
      s_tdata[c*DW +: DW] = base[c] + 16'(beat[c]);
      s_tlast[c] = (beat[c] == len[c]-1);
    end
    s_axis_fir_tvalid = res_en && (rq.size() > 0);
    s_axis_fir_tdata  = (rq.size() > 0) ? rq[0] : '0;
    s_axis_fir_tlast  = 1'b1;
  endtask

  task automatic tick();
    bit rfire;
    @(negedge clk);
    fire = s_tvalid & s_tready;
    if (m_axis_fir_tvalid && m_axis_fir_tready) begin
      mq_data.push_back(m_axis_fir_tdata);
      mq_last.push_back(m_axis_fir_tlast);
      mq_ch.push_back(oh2i(s_tready));
    end
    rfire = s_axis_fir_tvalid && s_axis_fir_tready;
    if (rfire) begin
      rl_data.push_back(res_tdata);
      rl_ch.push_back(oh2i(res_tvalid));
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < NC; c++) begin
      if (fire[c]) begin
        if (beat[c] == len[c]-1) begin
          beat[c] = 0;
          pkts[c]--;
        end else begin
          beat[c]++;
        end
      end
    end
    if (rfire) void'(rq.pop_front());
    drive();
  endtask

  task automatic clear();
    for (int c = 0; c < NC; c++) begin
      pkts[c] = 0;
      beat[c] = 0;
      len[c]  = 1;
      base[c] = '0;
    end
    res_en = 1'b0;
    m_axis_fir_tready = 1'b1;
    res_tready = '1;
    mq_data.delete();
    mq_last.delete();
    mq_ch.delete();
    rq.delete();
    rl_data.delete();
    rl_ch.delete();
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    clear();
    drive();
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1;
    assert_reset();
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_axis_fir_tvalid, 0);
    check("rst_res_tvalid", res_tvalid, 0);
    check("rst_fir_tready", s_axis_fir_tready, 0);
    check("rst_stat", stat_pkts, 0);
    release_reset();

    // single channel 2, 8-beat packet
    len[2] = 8; base[2] = 16'h5A7E; pkts[2] = 1;
    drive();
    tick();
    check("t1_lat1_valid", m_axis_fir_tvalid, 0);
    tick();
    check("t1_lat2_valid", m_axis_fir_tvalid, 1);
    check("t1_s_tready", s_tready, 4'b0100);
    for (int k = 0; k < 30 && mq_data.size() < 8; k++) tick();
    check("t1_beats", mq_data.size(), 8);
    if (mq_data.size() == 8) begin
      check("t1_data0", mq_data[0], 16'h5A7E);
      check("t1_data7", mq_data[7], 16'h5A85);
      check("t1_last7", mq_last[7], 1);
      check("t1_last6", mq_last[6], 0);
      check("t1_ch", mq_ch[7], 2);
    end
    rq.push_back(32'hCAFE0002); res_en = 1'b1;
    drive();
    #1;
    check("t1_tag_res_tvalid", res_tvalid, 4'b0100);
    check("t1_tag_fir_tready", s_axis_fir_tready, 1);
    for (int k = 0; k < 10 && rl_data.size() < 1; k++) tick();
    check("t1_res_cnt", rl_data.size(), 1);
    if (rl_data.size() == 1) check("t1_res_data", rl_data[0], 32'hCAFE0002);

    // all channels, 2-beat packets, round robin from reset
    assert_reset();
    release_reset();
    for (int c = 0; c < NC; c++) begin
      len[c] = 2; pkts[c] = 1; base[c] = 16'(c * 16'h1000);
    end
    pkts[0] = 2;
    for (int i = 0; i < 5; i++) rq.push_back(32'hD0000000 + 32'(i));
    res_en = 1'b1;
    drive();
    for (int k = 0; k < 100 && (mq_data.size() < 10 || rl_data.size() < 5); k++) tick();
    check("t2_beats", mq_data.size(), 10);
    seq = '0;
    foreach (mq_ch[i]) seq = {seq[59:0], 4'(mq_ch[i])};
    check("t2_beat_order", seq, 64'h0011223300);
    seq = '0;
    foreach (rl_ch[i]) seq = {seq[59:0], 4'(rl_ch[i])};
    check("t2_res_order", seq, 64'h01230);
`ifdef FIR_ARB_STATS_EN
    check("t2_stat", stat_pkts, 64'h0001_0001_0001_0002);
`else
    check("t2_stat", stat_pkts, 64'h0);
`endif

    // backpressure mid-packet
    assert_reset();
    release_reset();
    len[1] = 4; base[1] = 16'h1000; pkts[1] = 1;
    drive();
    for (int k = 0; k < 20 && mq_data.size() < 2; k++) tick();
    m_axis_fir_tready = 1'b0;
    drive();
    #1;
    check("t3_stall_s_tready", s_tready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_hold_data", m_axis_fir_tdata, 16'h1002);
      check("t3_hold_valid", m_axis_fir_tvalid, 1);
    end
    m_axis_fir_tready = 1'b1;
    drive();
    for (int k = 0; k < 20 && mq_data.size() < 4; k++) tick();
    check("t3_beats", mq_data.size(), 4);
    seq = '0;
    foreach (mq_data[i]) seq = {seq[47:0], mq_data[i]};
    check("t3_seq", seq, 64'h1000_1001_1002_1003);

    // tag FIFO full: fifth packet waits for a result pop
    assert_reset();
    release_reset();
    len[3] = 1; base[3] = 16'h3000; pkts[3] = 5;
    drive();
    repeat (40) tick();
    check("t4_stalled_beats", mq_data.size(), 4);
    check("t4_stalled_valid", m_axis_fir_tvalid, 0);
    rq.push_back(32'hBEEF0003); res_en = 1'b1;
    drive();
    for (int k = 0; k < 20 && mq_data.size() < 5; k++) tick();
    check("t4_after_pop_beats", mq_data.size(), 5);
    check("t4_res_cnt", rl_ch.size(), 1);
    if (rl_ch.size() == 1) check("t4_res_ch", rl_ch[0], 3);

    // result demux with channel 3 backpressured
    assert_reset();
    release_reset();
    base[1] = 16'h1111; base[3] = 16'h3333;
    pkts[1] = 1; pkts[3] = 1;
    res_tready = 4'b0111;
    drive();
    for (int k = 0; k < 20 && mq_data.size() < 2; k++) tick();
    check("t5_beats", mq_data.size(), 2);
    if (mq_ch.size() == 2) check("t5_grant_ch", {mq_ch[0][3:0], mq_ch[1][3:0]}, 8'h13);
    rq.push_back(32'hA1); rq.push_back(32'hA3); res_en = 1'b1;
    drive();
    for (int k = 0; k < 10 && rl_ch.size() < 1; k++) tick();
    check("t5_res1_cnt", rl_ch.size(), 1);
    if (rl_ch.size() >= 1) check("t5_res1_ch", rl_ch[0], 1);
    repeat (3) tick();
    check("t5_res3_held", rl_ch.size(), 1);
    check("t5_fir_tready", s_axis_fir_tready, 0);
    check("t5_res_tvalid", res_tvalid, 4'b1000);
    res_tready = '1;
    drive();
    for (int k = 0; k < 10 && rl_ch.size() < 2; k++) tick();
    check("t5_res3_cnt", rl_ch.size(), 2);
    if (rl_ch.size() == 2) check("t5_res3_data", rl_data[1], 32'hA3);

    // reset mid-packet, then a fresh channel 0 packet
    assert_reset();
    release_reset();
    len[0] = 4; base[0] = 16'h0A00; pkts[0] = 1;
    drive();
    for (int k = 0; k < 20 && mq_data.size() < 1; k++) tick();
    reset = 1'b1;
    #1;
    check("t6_rst_m_tvalid", m_axis_fir_tvalid, 0);
    check("t6_rst_s_tready", s_tready, 0);
    check("t6_rst_fir_tready", s_axis_fir_tready, 0);
    clear();
    drive();
    release_reset();
    base[0] = 16'h0B00; pkts[0] = 1;
    rq.push_back(32'hC0); res_en = 1'b1;
    drive();
    for (int k = 0; k < 20 && rl_ch.size() < 1; k++) tick();
    check("t6_beats", mq_data.size(), 1);
    if (mq_data.size() == 1) check("t6_data", mq_data[0], 16'h0B00);
    check("t6_res_cnt", rl_ch.size(), 1);
    if (rl_ch.size() == 1) check("t6_res_ch", rl_ch[0], 0);
`ifdef FIR_ARB_STATS_EN
    check("t6_stat0", stat_pkts[15:0], 16'd1);
`else
    check("t6_stat0", stat_pkts[15:0], 16'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fir_stream_arbiter.md
FIR_STREAM_ARBITER -- requirements
Module: fir_stream_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4; number of requester channels.
REQ-002 Parameter DATA_W, default 16; signed sample width.
REQ-003 Parameter RES_W, default 32; FIR result width.
REQ-004 Parameter TAG_DEPTH, default 4; packets in flight through FIR (power of 2).
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high.
REQ-007 s_tdata  in  NUM_CH*DATA_W  per-channel sample, channel c at bits [c*DATA_W +: DATA_W].
REQ-008 s_tvalid / s_tlast  in  NUM_CH each  per-channel valid / packet end.
REQ-009 s_tready  out  NUM_CH  per-channel ready.
REQ-010 m_axis_fir_tdata  out  DATA_W  sample to FIR; m_axis_fir_tvalid, m_axis_fir_tlast out 1; m_axis_fir_tready in 1.
REQ-011 s_axis_fir_tdata  in  RES_W  FIR result; s_axis_fir_tvalid, s_axis_fir_tlast in 1; s_axis_fir_tready out 1.
REQ-012 res_tdata  out  RES_W  shared result bus; res_tlast out 1; res_tvalid out NUM_CH; res_tready in NUM_CH.
REQ-013 stat_pkts  out  NUM_CH*16  per-channel completed-packet counters (see Configuration).

Function
REQ-014 FSM states: IDLE, ARB, XFER; IDLE->ARB when any s_tvalid high; ARB->XFER when a channel is granted; XFER->IDLE on accepted beat with s_tlast.
REQ-015 ARB grants round-robin, searching from (last_grant+1) mod NUM_CH; first reset search starts at channel 0.
REQ-016 Grant only when tag FIFO count < TAG_DEPTH; otherwise stay in ARB; a same-cycle pop does not enable grant.
REQ-017 Grant pushes granted channel index into tag FIFO in the ARB->XFER cycle.
REQ-018 In XFER, m_axis_fir_tdata/tvalid/tlast = granted channel's inputs combinationally; s_tready[g] = m_axis_fir_tready; all other s_tready = 0.
REQ-019 Outside XFER, m_axis_fir_tvalid = 0 and all s_tready = 0.
REQ-020 Grant is held for a whole packet; no preemption mid-packet regardless of other requests.
REQ-021 Result demux: when tag FIFO non-empty with head h, res_tvalid[h] = s_axis_fir_tvalid, other res_tvalid bits 0, s_axis_fir_tready = res_tready[h], res_tdata/res_tlast pass through.
REQ-022 Tag FIFO empty: s_axis_fir_tready = 0, res_tvalid = 0.
REQ-023 Pop tag on accepted result beat with s_axis_fir_tlast; head advances next cycle; pointers wrap mod TAG_DEPTH.
REQ-024 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-025 Minimum 2 cycles between packets on the FIR input side (IDLE/ARB); latency from s_tvalid to first m_axis_fir_tvalid = 2 cycles.

Reset
REQ-026 On reset: state IDLE, last_grant = NUM_CH-1, FIFO pointers/count 0, all s_tready/res_tvalid/m_axis_fir_tvalid/s_axis_fir_tready 0, stat_pkts 0.
REQ-027 Reset mid-packet abandons the packet and all in-flight tags; no recovery of partial packets.

Configuration
REQ-028 Macro FIR_ARB_STATS_EN defined: stat_pkts[c] increments on each popped tag for channel c, saturating at 16'hFFFF.
REQ-029 Macro undefined: stat_pkts tied to 0, no counter registers synthesised; port list unchanged.

Structure
REQ-030 Shared package fir_arb_pkg holds FSM state typedef, default NUM_CH/DATA_W/RES_W/TAG_DEPTH constants, channel-index width constant.
REQ-031 Tag FIFO is sub-module fir_arb_tag_fifo (synchronous, width clog2(NUM_CH), depth TAG_DEPTH, push/pop/full/empty/count).

Verification
REQ-032 Single channel 2 sends 8-beat packet 16'h5A7E..., FIR ready=1 -> grant 2, 8 beats on m_axis_fir with tlast on beat 8, tag 2 pushed.
REQ-033 All 4 channels valid continuously, 2-beat packets -> grant order 0,1,2,3,0; no beat interleaving between channels.
REQ-034 m_axis_fir_tready low 3 cycles mid-packet -> data held stable, s_tready[g]=0, no beat lost or duplicated.
REQ-035 Five packets granted with FIR results withheld -> fifth request stalls in ARB until first result tlast pops a tag.
REQ-036 Results returned for tags 1,3 with res_tready[3]=0 -> channel-1 result delivered, then channel-3 stalls, s_axis_fir_tready=0 until res_tready[3]=1.
REQ-037 Reset asserted mid-packet, then channel 0 packet -> outputs zero during reset, grant 0 after release; with FIR_ARB_STATS_EN, stat_pkts[0]=1 after its result completes.
